regfile_param: RTL

Parametrised multi-port register file generalising the single 32-bit enabled register: DEPTH words of WIDTH bits, one write port with byte enables, two asynchronous read ports with optional same-cycle write bypass, an optional hardwired zero register, and per-entry written-since-reset tracking. Sits between decode and execute as the architectural register storage of the datapath.

---
 rtl/regfile_param.sv | 99 +++++++++
 1 files changed

// File: rtl/regfile_param.sv
// regfile_param
//   Architectural register storage between decode and execute: DEPTH words
//   of WIDTH bits with one byte-enabled write port, two combinational read
//   ports (optional same-cycle write bypass), an optional hardwired zero
//   entry and per-entry written-since-reset tracking.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; clears words, valid, valid_count
//   wr_enable    write strobe
//   wr_addr      write address (AW bits)
//   wr_data      write data (WIDTH bits)
//   wr_byte_en   per-byte write mask, bit i covers bits 8i+7:8i
//   rd_addr_a/b  read addresses
//   rd_data_a/b  read data (0 for out-of-range or zero-register reads)
//   valid        bit i set once entry i has been written since reset
//   valid_count  registered popcount of valid
module regfile_param #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  parameter int unsigned AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_enable,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_byte_en,
  input  logic [AW-1:0]      rd_addr_a,
  input  logic [AW-1:0]      rd_addr_b,
  output logic [WIDTH-1:0]   rd_data_a,
  output logic [WIDTH-1:0]   rd_data_b,
  output logic [DEPTH-1:0]   valid,
  output logic [AW:0]        valid_count
);

  localparam int unsigned NBYTES = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_eff;
  logic [WIDTH-1:0] wr_merged;

  // Entry is backed by real storage and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] addr);
    return (32'(addr) < DEPTH) && !(ZERO_REG && (addr == '0));
  endfunction

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0]  old_word,
                                             input logic [WIDTH-1:0]  new_word,
                                             input logic [NBYTES-1:0] be);
    logic [WIDTH-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // Reset suppresses the write, so a write during reset is never bypassed
  // to the read ports either.
  always_comb begin
    wr_eff    = wr_enable && !reset && (wr_byte_en != '0) && addr_ok(wr_addr);
    wr_merged = '0;
    if (wr_eff) wr_merged = merge(mem[wr_addr], wr_data, wr_byte_en);
  end

  always_comb begin
    rd_data_a = '0;
    if (addr_ok(rd_addr_a)) begin
      rd_data_a = mem[rd_addr_a];
      if (BYPASS && wr_eff && (wr_addr == rd_addr_a)) rd_data_a = wr_merged;
    end
  end

  always_comb begin
    rd_data_b = '0;
    if (addr_ok(rd_addr_b)) begin
      rd_data_b = mem[rd_addr_b];
      if (BYPASS && wr_eff && (wr_addr == rd_addr_b)) rd_data_b = wr_merged;
    end
  end

  // valid_count is kept as its own register and only bumped when a write
  // lands on a not-yet-valid entry, so it tracks popcount(valid) exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid       <= '0;
      valid_count <= '0;
    end else if (wr_eff) begin
      mem[wr_addr]   <= wr_merged;
      valid[wr_addr] <= 1'b1;
      if (!valid[wr_addr]) valid_count <= valid_count + {{AW{1'b0}}, 1'b1};
    end
  end

endmodule
